// File: rtl/shift_tx_pkg.sv
// Shared constants for the serial transmitter: FSM state encoding and
// the helper that sizes the bit counter.
package shift_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a word of n bits (n >= 2).
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/shift_tx_if.sv
// Load and serial-side signals of the transmitter, bundled with
// master (producer/sink side) and slave (transmitter side) modports.
interface shift_tx_if #(
  parameter int N_WIDTH = 4
);

  // Handshakes: a transfer happens on a rising clk edge where valid and
  // ready are both 1. valid never waits for ready; the offered payload
  // (data_in/msb_first, or ser_out/ser_last) is held stable until taken.
  logic [N_WIDTH-1:0] data_in;
  logic               load_valid;
  logic               load_ready;
  logic               msb_first;
  logic               ser_out;
  logic               ser_valid;
  logic               ser_ready;
  logic               ser_last;
  logic               busy;

  modport master (
    output data_in, load_valid, msb_first, ser_ready,
    input  load_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  data_in, load_valid, msb_first, ser_ready,
    output load_ready, ser_out, ser_valid, ser_last, busy
  );

endinterface

// File: rtl/shift_tx_bit_counter.sv
// Bit-position counter for one word: counts consumed bits and flags the
// final bit. Saturates at N_WIDTH-1 so it can never wrap mid-word.
module tx_bit_counter
  import shift_tx_pkg::*;
#(
  parameter int N_WIDTH = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int CW = cnt_width(N_WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign last_o = (count_q == LAST_IDX);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !last_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter: accepts an N_WIDTH word, then shifts it
// out one bit per accepted serial beat in the requested bit order.
module shift_tx
  import shift_tx_pkg::*;
#(
  parameter int N_WIDTH = 4
) (
  input  logic   clk,
  input  logic   clear,
  shift_tx_if.slave bus,
  output state_e dbg_state_o
);

  state_e             state_q;
  state_e             state_d;
  logic [N_WIDTH-1:0] sreg_q;
  logic [N_WIDTH-1:0] sreg_d;
  logic               order_q;
  logic               order_d;

  logic shifting;
  logic cnt_last;
  logic last_bit;
  logic load_ready;
  logic accept;
  logic advance;
  logic cnt_clr;

  assign shifting   = (state_q == ST_SHIFT);
  assign last_bit   = shifting & cnt_last;
  assign load_ready = ~shifting | (last_bit & bus.ser_ready);
  assign accept     = bus.load_valid & load_ready;
  assign advance    = shifting & bus.ser_ready;
  // Counter restarts both for a new word and when a word completes, so
  // an idle transmitter always holds a zero count.
  assign cnt_clr    = accept | (advance & last_bit);

  tx_bit_counter #(
    .N_WIDTH (N_WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .clear  (clear),
    .clr_i  (cnt_clr),
    .inc_i  (advance),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    order_d = order_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (advance && last_bit && !accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      sreg_d  = bus.data_in;
      order_d = bus.msb_first;
    end else if (advance) begin
      sreg_d = order_q ? {sreg_q[N_WIDTH-2:0], 1'b0}
                       : {1'b0, sreg_q[N_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      order_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      order_q <= order_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_valid  = shifting;
  assign bus.busy       = shifting;
  assign bus.ser_last   = last_bit;
  assign bus.ser_out    = shifting & (order_q ? sreg_q[N_WIDTH-1] : sreg_q[0]);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_shift_tx.sv
// Bench for shift_tx: directed scenarios plus random traffic, checked
// against a bit-queue reference model of the word stream.
module tb_shift_tx;
  import shift_tx_pkg::*;

  localparam int N = 4;

  logic   clk   = 1'b0;
  logic   clear = 1'b0;
  state_e dbg_state;

  shift_tx_if #(.N_WIDTH(N)) bus();

  shift_tx #(.N_WIDTH(N)) dut (
    .clk         (clk),
    .clear       (clear),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Each entry is {is_last, bit}; exp_q holds the remaining bits of the
  // word in flight, obs_q logs every bit the sink consumed.
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  logic       snap_fire = 1'b0;
  logic [1:0] snap_bit  = 2'b00;
  logic       m_fire;
  logic       m_ready;
  logic       e_valid;
  logic       e_ready;
  logic [1:0] e_head;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: acceptance and consumption decided from the queue.
  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      exp_q.delete();
    end else begin
      if (snap_fire) obs_q.push_back(snap_bit);
      m_fire  = (exp_q.size() > 0) && bus.ser_ready;
      m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.ser_ready);
      if (m_fire) void'(exp_q.pop_front());
      if (m_ready && bus.load_valid) begin
        for (int i = 0; i < N; i++) begin
          exp_q.push_back({(i == N - 1) ? 1'b1 : 1'b0,
                           bus.data_in[bus.msb_first ? (N - 1 - i) : i]});
        end
      end
    end
  end

  always @(negedge clk) begin
    e_valid = (exp_q.size() > 0);
    e_head  = e_valid ? exp_q[0] : 2'b00;
    e_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.ser_ready);
    check("ser_valid",  bus.ser_valid,  e_valid);
    check("busy",       bus.busy,       e_valid);
    check("ser_out",    bus.ser_out,    e_head[0]);
    check("ser_last",   bus.ser_last,   e_head[1]);
    check("load_ready", bus.load_ready, e_ready);
    check("dbg_state",  dbg_state,      e_valid ? ST_SHIFT : ST_IDLE);
    snap_fire = clear & bus.ser_valid & bus.ser_ready;
    snap_bit  = {bus.ser_last, bus.ser_out};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [N-1:0] d, input logic msb);
    bus.data_in    = d;
    bus.msb_first  = msb;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
  endtask

  // Compares the bits logged since index base against a bit vector whose
  // element 0 is the first bit expected on the line.
  task automatic expect_obs(input string tag, input int base, input logic [7:0] bits, input int n);
    check({tag, "_len"}, obs_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < obs_q.size()) begin
        check({tag, "_bit"},  obs_q[base+i][0], bits[i]);
        check({tag, "_last"}, obs_q[base+i][1], (i % N) == N - 1);
      end
    end
  endtask

  int base;

  initial begin
    bus.data_in    = '0;
    bus.load_valid = 1'b0;
    bus.msb_first  = 1'b0;
    bus.ser_ready  = 1'b1;
    #1;
    check("rst_valid", bus.ser_valid, 0);
    check("rst_ready", bus.load_ready, 1);
    check("rst_out",   bus.ser_out, 0);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    step();

    // LSB-first single word
    base = obs_q.size();
    load(4'b1011, 1'b0);
    repeat (5) step();
    expect_obs("lsb_word", base, 8'b0000_1011, 4);
    check("lsb_idle", bus.busy, 0);

    // MSB-first single word
    base = obs_q.size();
    load(4'b1011, 1'b1);
    repeat (5) step();
    expect_obs("msb_word", base, 8'b0000_1101, 4);

    // Stall on the second bit
    base = obs_q.size();
    load(4'b1011, 1'b0);
    step();
    bus.ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_out",   bus.ser_out, 1);
      check("stall_valid", bus.ser_valid, 1);
      step();
    end
    bus.ser_ready = 1'b1;
    repeat (4) step();
    expect_obs("stall_word", base, 8'b0000_1011, 4);

    // Back-to-back words with load_valid held
    base = obs_q.size();
    load(4'hA, 1'b0);
    bus.data_in    = 4'h5;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b2b_ready", bus.load_ready, i == 3);
      check("b2b_valid", bus.ser_valid, 1);
      step();
    end
    bus.load_valid = 1'b0;
    check("b2b_gap", bus.ser_valid, 1);
    repeat (5) step();
    expect_obs("b2b_words", base, 8'b0101_1010, 8);

    // Asynchronous clear mid-word, then a fresh word
    load(4'hF, 1'b0);
    step();
    step();
    #2 clear = 1'b0;
    #1;
    check("aclr_valid", bus.ser_valid, 0);
    check("aclr_out",   bus.ser_out, 0);
    check("aclr_ready", bus.load_ready, 1);
    check("aclr_busy",  bus.busy, 0);
    @(negedge clk);
    clear = 1'b1;
    step();
    base = obs_q.size();
    load(4'h3, 1'b0);
    repeat (5) step();
    expect_obs("post_clr", base, 8'b0000_0011, 4);

    // Mid-word load attempt with changed data and order is ignored
    base = obs_q.size();
    load(4'b1011, 1'b0);
    step();
    bus.data_in    = 4'h0;
    bus.msb_first  = 1'b1;
    bus.load_valid = 1'b1;
    step();
    bus.load_valid = 1'b0;
    repeat (4) step();
    expect_obs("ignore_mid", base, 8'b0000_1011, 4);

    // Random traffic, checked every cycle by the model
    for (int k = 0; k < 3000; k++) begin
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.data_in    = 4'($urandom_range(0, 15));
      bus.msb_first  = 1'($urandom_range(0, 1));
      bus.ser_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.load_valid = 1'b0;
    bus.ser_ready  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain", exp_q.size(), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_tx.md
SHIFT_TX -- requirements
Module: shift_tx

Interface
REQ-001 SHALL have parameter N_WIDTH, default 4, word width in bits; legal range N_WIDTH >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port clear  input  1  asynchronous, active-low reset (clear=0 resets).
REQ-004 SHALL have port data_in  input  N_WIDTH  parallel word to transmit.
REQ-005 SHALL have port load_valid  input  1  producer offers data_in.
REQ-006 SHALL have port load_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port msb_first  input  1  bit order for the offered word (1 = MSB first, 0 = LSB first).
REQ-008 SHALL have port ser_out  output  1  current serial bit.
REQ-009 SHALL have port ser_valid  output  1  ser_out carries a valid bit.
REQ-010 SHALL have port ser_ready  input  1  sink consumes ser_out this cycle.
REQ-011 SHALL have port ser_last  output  1  ser_out is the final bit of the word.
REQ-012 SHALL have port busy  output  1  a word is in flight.

Function
REQ-013 SHALL implement FSM states IDLE and SHIFT; a load is accepted on a rising edge with load_valid=1 and load_ready=1.
REQ-014 SHALL, in IDLE, drive load_ready=1, ser_valid=0, ser_last=0, busy=0 and ser_out=0.
REQ-015 SHALL, on acceptance, capture data_in into an N_WIDTH shift register and msb_first into an order flag, clear the bit counter, and enter SHIFT.
REQ-016 SHALL present the first bit in the cycle after acceptance (latency 1 cycle); ser_valid=1 and busy=1 throughout SHIFT.
REQ-017 SHALL drive ser_out = shift register bit N_WIDTH-1 when the order flag is 1, and bit 0 otherwise.
REQ-018 SHALL advance only on an edge with ser_valid=1 and ser_ready=1: shift one position toward the output end (zero fill) and increment the counter.
REQ-019 SHALL hold ser_out, the counter and the shift register unchanged while ser_ready=0 (stall of any length).
REQ-020 SHALL assert ser_last when counter = N_WIDTH-1; the counter is $clog2(N_WIDTH) bits wide and never wraps past N_WIDTH-1.
REQ-021 SHALL drive load_ready = IDLE OR (ser_last AND ser_ready).
REQ-022 SHALL, when the last bit is consumed and a load is accepted on the same edge, reload and remain in SHIFT with no idle gap between words.
REQ-023 SHALL, when the last bit is consumed and no load is accepted, return to IDLE.
REQ-024 SHALL ignore load_valid, data_in and msb_first while load_ready=0; changes on these inputs mid-word have no effect.

Reset
REQ-025 SHALL, while clear=0, force IDLE, zero the shift register, counter and order flag, and drive ser_out=0, ser_valid=0, ser_last=0, busy=0, load_ready=1 (asynchronously, independent of clk).
REQ-026 SHALL discard a partially sent word on reset; after clear returns to 1, the next accepted word is sent from its first bit.

Structure
REQ-027 SHALL place the state encoding constants ST_IDLE and ST_SHIFT in the team's shared constants package; N_WIDTH remains a module parameter.
REQ-028 SHALL implement the bit counter with its last-bit compare as one sub-module, tx_bit_counter; the FSM and shift register stay in shift_tx.

Verification (N_WIDTH=4, ser_ready=1 unless stated)
REQ-029 SHALL cover: load 4'b1011 with msb_first=0 -> ser_out 1,1,0,1 on 4 consecutive cycles, ser_last only on the 4th, then IDLE.
REQ-030 SHALL cover: load 4'b1011 with msb_first=1 -> ser_out 1,0,1,1, ser_last on the 4th bit.
REQ-031 SHALL cover: load 4'b1011 with msb_first=0 and ser_ready=0 for 3 cycles during the 2nd bit -> ser_out holds 1, ser_valid stays 1, sequence completes as 1,1,0,1.
REQ-032 SHALL cover: 4'hA then 4'h5 (msb_first=0), second load_valid held from the first load -> 8 contiguous valid bits 0,1,0,1,1,0,1,0, load_ready high only on the last-bit cycle, no gap.
REQ-033 SHALL cover: clear=0 after 2 bits of 4'hF -> ser_valid=0, ser_out=0 and load_ready=1 without a clock edge; the next word 4'h3 is sent as 1,1,0,0.
REQ-034 SHALL cover: data_in changed and load_valid pulsed mid-word -> no effect on the current bit stream and no extra word accepted.
